// File: rtl/ysyx_24100006_muldiv_pkg.sv
// Shared types and op-decode helpers for the RV32M multiply/divide unit.
// The op encoding follows funct3, so the ID stage can pass funct3 straight through.
package ysyx_24100006_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic logic is_div(input muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    // MUL only uses the low half, which is identical for any signedness.
    function automatic logic is_signed_a(input muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic want_high(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

endpackage

// File: rtl/ysyx_24100006_div_iter.sv
// One radix-2 restoring-divide step on unsigned magnitudes.
// quo shifts the dividend out at the top and the new quotient bit in at the bottom.
module ysyx_24100006_div_iter #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    // rem < divisor always holds, so diff[XLEN] is a clean borrow flag.
    assign shifted  = {rem, quo[XLEN-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign fits     = ~diff[XLEN];
    assign rem_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], fits};

endmodule

// File: rtl/ysyx_24100006_exe_muldiv.sv
// Multi-cycle RV32M MUL/DIV/REM unit with valid/ready on both sides and a pass-through tag.
// Define YSYX_24100006_FAST_MUL_EN to compute MUL* in a single cycle instead of shift-add.
module ysyx_24100006_exe_muldiv
    import ysyx_24100006_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // out_valid, result and tag_out stay fixed until that transfer (or a flush/reset).
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    logic [CW-1:0]   cnt;
    muldiv_op_t      op_r;
    logic            neg_q, neg_r;
    logic [XLEN-1:0] rem_r, quo_r, dvs_r, result_r;
    logic [TAG_W-1:0] tag_r;

    muldiv_op_t      op_i;
    logic            a_neg, b_neg, div_zero, ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;

    assign op_i     = muldiv_op_t'(op);
    assign a_neg    = is_signed_a(op_i) && rs1[XLEN-1];
    assign b_neg    = is_signed_b(op_i) && rs2[XLEN-1];
    assign mag_a    = a_neg ? -rs1 : rs1;
    assign mag_b    = b_neg ? -rs2 : rs2;
    assign div_zero = (rs2 == '0);
    assign ovf      = is_signed_a(op_i) && (rs1 == MIN_INT) && (rs2 == '1);
    assign special  = is_div(op_i) && (div_zero || ovf);
    assign spec_res = div_zero ? (is_rem(op_i) ? rs1 : '1) : (is_rem(op_i) ? '0 : MIN_INT);

    // Divide and multiply share rem_r/quo_r/dvs_r: for multiply they hold the
    // product high half, product low half (multiplier shifting out) and multiplicand.
    logic [XLEN-1:0] div_rem_n, div_quo_n;
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_n, mul_lo_n, step_rem, step_quo;

    ysyx_24100006_div_iter #(.XLEN(XLEN)) u_div_iter (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvs_r),
        .rem_next (div_rem_n),
        .quo_next (div_quo_n)
    );

    assign mul_sum  = {1'b0, rem_r} + {1'b0, {XLEN{quo_r[0]}} & dvs_r};
    assign mul_hi_n = mul_sum[XLEN:1];
    assign mul_lo_n = {mul_sum[0], quo_r[XLEN-1:1]};
    assign step_rem = is_div(op_r) ? div_rem_n : mul_hi_n;
    assign step_quo = is_div(op_r) ? div_quo_n : mul_lo_n;

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    assign prod      = {mul_hi_n, mul_lo_n};
    assign prod_fix  = neg_q ? -prod : prod;
    assign quo_fix   = neg_q ? -div_quo_n : div_quo_n;
    assign rem_fix   = neg_r ? -div_rem_n : div_rem_n;
    assign final_res = is_div(op_r) ? (is_rem(op_r) ? rem_fix : quo_fix)
                     : (want_high(op_r) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0]);

`ifdef YSYX_24100006_FAST_MUL_EN
    localparam logic FAST_MUL = 1'b1;
    logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
    logic [XLEN-1:0]   fast_res;
    // Extending to 2*XLEN and keeping the low 2*XLEN bits gives the exact product.
    assign ext_a     = {{XLEN{is_signed_a(op_i) && rs1[XLEN-1]}}, rs1};
    assign ext_b     = {{XLEN{is_signed_b(op_i) && rs2[XLEN-1]}}, rs2};
    assign fast_prod = ext_a * ext_b;
    assign fast_res  = want_high(op_i) ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0];
`else
    localparam logic FAST_MUL = 1'b0;
    logic [XLEN-1:0] fast_res;
    assign fast_res = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_r     <= OP_MUL;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            rem_r    <= '0;
            quo_r    <= '0;
            dvs_r    <= '0;
            result_r <= '0;
            tag_r    <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_r  <= op_i;
                    tag_r <= tag_in;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    rem_r <= '0;
                    quo_r <= is_div(op_i) ? mag_a : mag_b;
                    dvs_r <= is_div(op_i) ? mag_b : mag_a;
                    cnt   <= '0;
                    if (special) begin
                        result_r <= spec_res;
                        state    <= DONE;
                    end else if (FAST_MUL && !is_div(op_i)) begin
                        result_r <= fast_res;
                        state    <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem_r <= step_rem;
                    quo_r <= step_quo;
                    if (cnt == CW'(XLEN-1)) begin
                        cnt      <= '0;
                        result_r <= final_res;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = result_r;
    assign tag_out   = tag_r;
    assign dbg_state = state;

endmodule
